// File: rtl/lzta_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lzta_accumulator                                             |
// | Description : Pipelined group accumulator with runtime-selectable adder    |
// |               mode (exact / LZTA / LOA / truncate) and valid/ready flow    |
// |               control. Optional build macro LZTA_ACC_SAT_EN makes the      |
// |               accumulator saturate on carry-out instead of wrapping.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lzta_accumulator #(
  parameter int DATA_WIDTH     = 16,
  parameter int ACC_WIDTH      = 24,
  parameter int IMPRECISE_PART = 8,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf
);

  localparam int K  = IMPRECISE_PART;
  localparam int UW = ACC_WIDTH - IMPRECISE_PART;

  localparam logic [1:0] MODE_EXACT = 2'b00;
  localparam logic [1:0] MODE_LZTA  = 2'b01;
  localparam logic [1:0] MODE_LOA   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   ovf;
  logic [1:0]             mode_q;

  logic                   accept;
  logic                   first;
  logic [ACC_WIDTH-1:0]   base;
  logic [1:0]             add_mode;
  logic [ACC_WIDTH-1:0]   d_ext;
  logic [ACC_WIDTH:0]     exact_full;
  logic [UW:0]            upper_full;
  logic                   cin;
  logic [K-1:0]           low_part;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_carry;
  logic                   ovf_next;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [CNT_WIDTH-1:0]   cnt_next;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs; out_valid depends on registered state only
  always_comb begin
    state_nxt = state;
    in_ready  = (state != S_HOLD) | out_ready;
    out_valid = (state == S_HOLD);
    accept    = in_valid & in_ready;
    if (accept)                             state_nxt = in_last ? S_HOLD : S_ACC;
    else if (state == S_HOLD && out_ready)  state_nxt = S_IDLE;
  end

  // Approximate adder: a new group starts from zero with the live mode input
  always_comb begin
    first      = (state != S_ACC);
    base       = first ? '0 : acc;
    add_mode   = first ? mode : mode_q;
    d_ext      = ACC_WIDTH'(in_data);
    exact_full = {1'b0, base} + {1'b0, d_ext};
    cin        = 1'b0;
    low_part   = '0;
    case (add_mode)
      MODE_LZTA: cin = base[K-1] | d_ext[K-1];
      MODE_LOA: begin
        cin      = base[K-1] & d_ext[K-1];
        low_part = base[K-1:0] | d_ext[K-1:0];
      end
      default: cin = 1'b0;
    endcase
    upper_full = {1'b0, base[ACC_WIDTH-1:K]} + {1'b0, d_ext[ACC_WIDTH-1:K]}
               + (UW+1)'(cin);
    if (add_mode == MODE_EXACT) begin
      add_sum   = exact_full[ACC_WIDTH-1:0];
      add_carry = exact_full[ACC_WIDTH];
    end else begin
      add_sum   = {upper_full[UW-1:0], low_part};
      add_carry = upper_full[UW];
    end
    ovf_next = (first ? 1'b0 : ovf) | add_carry;
`ifdef LZTA_ACC_SAT_EN
    // Once any add in the group has overflowed, the accumulator pins at all-ones
    acc_next = ovf_next ? '1 : add_sum;
`else
    acc_next = add_sum;
`endif
    if (first)          cnt_next = CNT_WIDTH'(1);
    else if (cnt == '1) cnt_next = cnt;
    else                cnt_next = cnt + CNT_WIDTH'(1);
  end

  // Accumulator, group bookkeeping and result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      mode_q    <= MODE_EXACT;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (accept) begin
      if (first) mode_q <= mode;
      if (in_last) begin
        out_sum   <= acc_next;
        out_count <= cnt_next;
        out_ovf   <= ovf_next;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_next;
        ovf <= ovf_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lzta_accumulator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_lzta_accumulator                                          |
// | Description : Directed self-checking bench for lzta_accumulator, default   |
// |               build plus a 16-bit instance for overflow behaviour.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_lzta_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Default-parameter instance
  logic [1:0]  mode = 2'b00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_sum;
  logic [7:0]  out_count;
  logic        out_ovf;

  // 16-bit accumulator instance
  logic [1:0]  mode_b = 2'b00;
  logic        in_valid_b = 1'b0;
  logic        in_ready_b;
  logic [15:0] in_data_b = '0;
  logic        in_last_b = 1'b0;
  logic        out_valid_b;
  logic        out_ready_b = 1'b1;
  logic [15:0] out_sum_b;
  logic [7:0]  out_count_b;
  logic        out_ovf_b;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  lzta_accumulator #(
    .DATA_WIDTH(16), .ACC_WIDTH(24), .IMPRECISE_PART(8), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf)
  );

  lzta_accumulator #(
    .DATA_WIDTH(16), .ACC_WIDTH(16), .IMPRECISE_PART(8), .CNT_WIDTH(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .in_data(in_data_b), .in_last(in_last_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_sum(out_sum_b),
    .out_count(out_count_b), .out_ovf(out_ovf_b)
  );

  // One beat on the default instance; outputs are sampled 1ns after the edge
  task automatic send(input logic [15:0] d, input logic last, input logic [1:0] m);
    in_valid = 1'b1; in_data = d; in_last = last; mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== 24'h0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b sum=%h cnt=%0d ovf=%b, want 0/000000/0/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_lzta();
    send(16'h00FF, 1'b0, 2'b01);
    send(16'h0081, 1'b1, 2'b01);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'h000200 || out_count !== 8'd2 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL lzta: got valid=%b sum=%h cnt=%0d ovf=%b, want 1/000200/2/0",
               out_valid, out_sum, out_count, out_ovf);
    end
  endtask

  task automatic test_loa();
    send(16'h00FF, 1'b0, 2'b10);
    send(16'h0081, 1'b1, 2'b10);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'h0001FF || out_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL loa: got valid=%b sum=%h cnt=%0d, want 1/0001ff/2",
               out_valid, out_sum, out_count);
    end
  endtask

  task automatic test_truncate_mode_latch();
    send(16'h1234, 1'b0, 2'b11);
    send(16'h0101, 1'b1, 2'b00);
    tests_run++;
    if (out_sum !== 24'h001300 || out_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL truncate_latch: got sum=%h cnt=%0d, want 001300/2", out_sum, out_count);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_sum;
`ifdef LZTA_ACC_SAT_EN
    exp_sum = 16'hFFFF;
`else
    exp_sum = 16'h0001;
`endif
    in_valid_b = 1'b1; in_data_b = 16'hFFFF; in_last_b = 1'b0; mode_b = 2'b00;
    @(posedge clk); #1;
    in_data_b = 16'h0002; in_last_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0; in_last_b = 1'b0;
    tests_run++;
    if (out_valid_b !== 1'b1 || out_sum_b !== exp_sum || out_ovf_b !== 1'b1 || out_count_b !== 8'd2) begin
      tests_failed++;
      $display("FAIL overflow: got valid=%b sum=%h ovf=%b cnt=%0d, want 1/%h/1/2",
               out_valid_b, out_sum_b, out_ovf_b, out_count_b, exp_sum);
    end
    // No carry in a later group: ovf must clear
    in_valid_b = 1'b1; in_data_b = 16'h0003; in_last_b = 1'b1;
    @(posedge clk); #1;
    in_valid_b = 1'b0; in_last_b = 1'b0;
    tests_run++;
    if (out_sum_b !== 16'h0003 || out_ovf_b !== 1'b0 || out_count_b !== 8'd1) begin
      tests_failed++;
      $display("FAIL overflow_clear: got sum=%h ovf=%b cnt=%0d, want 0003/0/1",
               out_sum_b, out_ovf_b, out_count_b);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send(16'h0020, 1'b1, 2'b00);
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 24'h000020 || out_count !== 8'd1) begin
        tests_failed++;
        $display("FAIL bp_hold[%0d]: got rdy=%b valid=%b sum=%h cnt=%0d, want 0/1/000020/1",
                 i, in_ready, out_valid, out_sum, out_count);
      end
      in_valid = (i == 2);  // an offered beat must be ignored while held
      in_data  = 16'h7777;
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    in_valid = 1'b1; in_data = 16'h0010; in_last = 1'b1; mode = 2'b00; out_ready = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_ready_comb: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'h000010 || out_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL bp_replace: got valid=%b sum=%h cnt=%0d, want 1/000010/1",
               out_valid, out_sum, out_count);
    end
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_drain: got valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    send(16'h0001, 1'b0, 2'b00);
    send(16'h0002, 1'b1, 2'b00);
    tests_run++;
    if (out_sum !== 24'h000003 || out_count !== 8'd2 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_g1: got sum=%h cnt=%0d valid=%b, want 000003/2/1", out_sum, out_count, out_valid);
    end
    send(16'h0003, 1'b1, 2'b00);
    tests_run++;
    if (out_sum !== 24'h000003 || out_count !== 8'd1 || out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_g2: got sum=%h cnt=%0d valid=%b, want 000003/1/1", out_sum, out_count, out_valid);
    end
    send(16'h0004, 1'b0, 2'b00);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_mid: got valid=%b want 0", out_valid);
    end
    send(16'h0005, 1'b1, 2'b00);
    tests_run++;
    if (out_sum !== 24'h000009 || out_count !== 8'd2) begin
      tests_failed++;
      $display("FAIL b2b_g3: got sum=%h cnt=%0d, want 000009/2", out_sum, out_count);
    end
  endtask

  task automatic test_count_saturation();
    for (int i = 0; i < 299; i++) send(16'h0001, 1'b0, 2'b00);
    send(16'h0001, 1'b1, 2'b00);
    tests_run++;
    if (out_count !== 8'hFF || out_sum !== 24'h00012C) begin
      tests_failed++;
      $display("FAIL count_sat: got cnt=%0d sum=%h, want 255/00012c", out_count, out_sum);
    end
  endtask

  task automatic test_reset_mid_group();
    send(16'h0011, 1'b0, 2'b00);
    send(16'h0022, 1'b0, 2'b00);
    send(16'h0033, 1'b0, 2'b00);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tests_run++;
    if (out_valid !== 1'b0 || out_sum !== 24'h0 || out_count !== 8'd0 || out_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got valid=%b sum=%h cnt=%0d ovf=%b, want 0/000000/0/0",
               out_valid, out_sum, out_count, out_ovf);
    end
    send(16'h0005, 1'b1, 2'b00);
    tests_run++;
    if (out_valid !== 1'b1 || out_sum !== 24'h000005 || out_count !== 8'd1) begin
      tests_failed++;
      $display("FAIL reset_fresh: got valid=%b sum=%h cnt=%0d, want 1/000005/1",
               out_valid, out_sum, out_count);
    end
  endtask

  initial begin
    test_reset();
    test_lzta();
    test_loa();
    test_truncate_mode_latch();
    test_overflow();
    test_back_pressure();
    test_back_to_back();
    test_count_saturation();
    test_reset_mid_group();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
